// File: rtl/ysyx_23060240_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060240_axi_pkg
// Brief  : Shared types and constants for the round-robin AXI4-Lite arbiter:
//          arbiter state encoding, AXI response codes and a small index
//          wrap helper used by the round-robin picker.
// Rev    : 1.0  initial release
// ============================================================================
package ysyx_23060240_axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } arb_state_t;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    // (base + off) mod n, valid while base < n and off < n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return ((base + off) >= n) ? (base + off - n) : (base + off);
    endfunction

endpackage : ysyx_23060240_axi_pkg
`default_nettype wire

// File: rtl/ysyx_23060240_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060240_rr_pick
// Brief  : Combinational round-robin picker. Selects the first asserted
//          request at or after ptr, wrapping from N-1 back to 0.
// Ports  : req  [N]      request vector
//          ptr  [IDX_W]  highest-priority index for this pick (must be < N)
//          gnt  [N]      one-hot of the selected requester (0 if none)
//          idx  [IDX_W]  index of the selected requester (0 if none)
//          any           at least one request present
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_23060240_rr_pick
    import ysyx_23060240_axi_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] w_cand;

    // Walk the requesters starting at ptr; the first hit wins and later
    // candidates are ignored through the any flag.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IDX_W'(rr_wrap(int'(ptr), k, N));
            if (!any && req[w_cand]) begin
                any         = 1'b1;
                idx         = w_cand;
                gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule : ysyx_23060240_rr_pick
`default_nettype wire

// File: rtl/ysyx_23060240_axi_rr_arb.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060240_axi_rr_arb
// Brief  : NUM_MST-master to 1-slave AXI4-Lite arbiter, round-robin fairness
//          across masters, one outstanding transaction at a time. Response
//          codes (rresp/bresp) are forwarded unmodified.
// Ports  : clk, rst_n (asynchronous, active-low)
//          m_ar*/m_aw*/m_w*  flattened per-master request channels,
//                            master i at slice [i*W +: W]
//          m_arready/m_awready/m_wready/m_rvalid/m_bvalid  per-master
//          m_rdata/m_rresp/m_bresp  broadcast, qualify with per-master valid
//          s_*               single slave port
//          perf_grant_cnt    per-master 32-bit grant counters (optional)
// Config : ARB_PERF_EN  when defined, adds the grant counters and the
//                       perf_grant_cnt output port.
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_23060240_axi_rr_arb
    import ysyx_23060240_axi_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // master side
    input  logic [NUM_MST*ADDR_W-1:0]     m_araddr,
    input  logic [NUM_MST-1:0]            m_arvalid,
    output logic [NUM_MST-1:0]            m_arready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [1:0]                    m_rresp,
    output logic [NUM_MST-1:0]            m_rvalid,
    input  logic [NUM_MST-1:0]            m_rready,
    input  logic [NUM_MST*ADDR_W-1:0]     m_awaddr,
    input  logic [NUM_MST-1:0]            m_awvalid,
    output logic [NUM_MST-1:0]            m_awready,
    input  logic [NUM_MST*DATA_W-1:0]     m_wdata,
    input  logic [NUM_MST*(DATA_W/8)-1:0] m_wstrb,
    input  logic [NUM_MST-1:0]            m_wvalid,
    output logic [NUM_MST-1:0]            m_wready,
    output logic [1:0]                    m_bresp,
    output logic [NUM_MST-1:0]            m_bvalid,
    input  logic [NUM_MST-1:0]            m_bready,
    // slave side
    output logic [ADDR_W-1:0]             s_araddr,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    input  logic [1:0]                    s_bresp,
    input  logic                          s_bvalid,
    output logic                          s_bready
`ifdef ARB_PERF_EN
    ,
    output logic [NUM_MST*32-1:0]         perf_grant_cnt
`endif
);

    localparam int IDX_W  = $clog2(NUM_MST);
    localparam int STRB_W = DATA_W / 8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_aw_done;
    logic             r_w_done;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_MST-1:0] w_req;
    logic [NUM_MST-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_pick_is_rd;

    assign w_req        = m_arvalid | m_awvalid | m_wvalid;
    // Read is preferred only within the selected master.
    assign w_pick_is_rd = |(w_pick_oh & m_arvalid);

    ysyx_23060240_rr_pick #(
        .N     (NUM_MST),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (w_req),
        .ptr (r_rr_ptr),
        .gnt (w_pick_oh),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // ------------------------------------------------------------------
    // Granted-master views
    // ------------------------------------------------------------------
    logic [NUM_MST-1:0] w_gnt_oh;
    logic               w_g_arvalid;
    logic               w_g_awvalid;
    logic               w_g_wvalid;
    logic               w_g_rready;
    logic               w_g_bready;

    always_comb begin
        w_gnt_oh = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            w_gnt_oh[i] = (r_grant == IDX_W'(i));
        end
    end

    assign w_g_arvalid = m_arvalid[r_grant];
    assign w_g_awvalid = m_awvalid[r_grant];
    assign w_g_wvalid  = m_wvalid[r_grant];
    assign w_g_rready  = m_rready[r_grant];
    assign w_g_bready  = m_bready[r_grant];

    // Buses follow the current grant regardless of state; the valids
    // below are what qualify them.
    assign s_araddr = m_araddr[r_grant*ADDR_W +: ADDR_W];
    assign s_awaddr = m_awaddr[r_grant*ADDR_W +: ADDR_W];
    assign s_wdata  = m_wdata[r_grant*DATA_W +: DATA_W];
    assign s_wstrb  = m_wstrb[r_grant*STRB_W +: STRB_W];

    assign m_rdata  = s_rdata;
    assign m_rresp  = s_rresp;
    assign m_bresp  = s_bresp;

    // ------------------------------------------------------------------
    // Handshake forwarding, gated by state
    // ------------------------------------------------------------------
    logic w_st_rd_addr;
    logic w_st_rd_data;
    logic w_st_wr_addr;
    logic w_st_wr_resp;

    assign w_st_rd_addr = (r_state == RD_ADDR);
    assign w_st_rd_data = (r_state == RD_DATA);
    assign w_st_wr_addr = (r_state == WR_ADDR);
    assign w_st_wr_resp = (r_state == WR_RESP);

    assign s_arvalid = w_st_rd_addr & w_g_arvalid;
    assign s_rready  = w_st_rd_data & w_g_rready;
    // Once a write channel has completed its handshake it is held off the
    // slave until the whole write finishes.
    assign s_awvalid = w_st_wr_addr & ~r_aw_done & w_g_awvalid;
    assign s_wvalid  = w_st_wr_addr & ~r_w_done & w_g_wvalid;
    assign s_bready  = w_st_wr_resp & w_g_bready;

    assign m_arready = w_gnt_oh & {NUM_MST{w_st_rd_addr & s_arready}};
    assign m_rvalid  = w_gnt_oh & {NUM_MST{w_st_rd_data & s_rvalid}};
    assign m_awready = w_gnt_oh & {NUM_MST{w_st_wr_addr & ~r_aw_done & s_awready}};
    assign m_wready  = w_gnt_oh & {NUM_MST{w_st_wr_addr & ~r_w_done & s_wready}};
    assign m_bvalid  = w_gnt_oh & {NUM_MST{w_st_wr_resp & s_bvalid}};

    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_wr_addr_fin;
    logic [IDX_W-1:0] w_next_ptr;

    assign w_ar_hs = s_arvalid & s_arready;
    assign w_r_hs  = s_rvalid & s_rready;
    assign w_aw_hs = s_awvalid & s_awready;
    assign w_w_hs  = s_wvalid & s_wready;
    assign w_b_hs  = s_bvalid & s_bready;

    // Both write channels done, in the same or in different cycles.
    assign w_wr_addr_fin = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    // The master just served drops to lowest priority.
    assign w_next_ptr = (r_grant == IDX_W'(NUM_MST - 1)) ? '0 : (r_grant + IDX_W'(1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick_idx;
                        r_state <= w_pick_is_rd ? RD_ADDR : WR_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (w_r_hs) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                WR_ADDR: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_wr_addr_fin) begin
                        r_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (w_b_hs) begin
                        r_state   <= IDLE;
                        r_rr_ptr  <= w_next_ptr;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional grant counters
    // ------------------------------------------------------------------
`ifdef ARB_PERF_EN
    logic [31:0] r_perf_cnt [NUM_MST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MST; i++) begin
                r_perf_cnt[i] <= '0;
            end
        end else if ((r_state == IDLE) && w_pick_any) begin
            r_perf_cnt[w_pick_idx] <= r_perf_cnt[w_pick_idx] + 32'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_perf
        assign perf_grant_cnt[gi*32 +: 32] = r_perf_cnt[gi];
    end
`endif

    // ------------------------------------------------------------------
    // Protocol checks: a granted master must hold a pending valid until
    // its handshake completes.
    // ------------------------------------------------------------------
    a_ar_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (w_st_rd_addr && w_g_arvalid && !s_arready) |=> w_g_arvalid);
    a_aw_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (w_st_wr_addr && !r_aw_done && w_g_awvalid && !s_awready) |=> w_g_awvalid);
    a_w_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (w_st_wr_addr && !r_w_done && w_g_wvalid && !s_wready) |=> w_g_wvalid);

endmodule : ysyx_23060240_axi_rr_arb
`default_nettype wire

// File: tb/tb_ysyx_23060240_axi_rr_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_ysyx_23060240_axi_rr_arb
// Brief  : Directed self-checking bench for the round-robin AXI4-Lite
//          arbiter with three masters. The slave side is driven by the
//          bench; expected values are hand-computed.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ysyx_23060240_axi_rr_arb;
    import ysyx_23060240_axi_pkg::*;

    localparam int NUM_MST = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_MST*ADDR_W-1:0]     m_araddr;
    logic [NUM_MST-1:0]            m_arvalid;
    logic [NUM_MST-1:0]            m_arready;
    logic [DATA_W-1:0]             m_rdata;
    logic [1:0]                    m_rresp;
    logic [NUM_MST-1:0]            m_rvalid;
    logic [NUM_MST-1:0]            m_rready;
    logic [NUM_MST*ADDR_W-1:0]     m_awaddr;
    logic [NUM_MST-1:0]            m_awvalid;
    logic [NUM_MST-1:0]            m_awready;
    logic [NUM_MST*DATA_W-1:0]     m_wdata;
    logic [NUM_MST*(DATA_W/8)-1:0] m_wstrb;
    logic [NUM_MST-1:0]            m_wvalid;
    logic [NUM_MST-1:0]            m_wready;
    logic [1:0]                    m_bresp;
    logic [NUM_MST-1:0]            m_bvalid;
    logic [NUM_MST-1:0]            m_bready;
    logic [ADDR_W-1:0]             s_araddr;
    logic                          s_arvalid;
    logic                          s_arready;
    logic [DATA_W-1:0]             s_rdata;
    logic [1:0]                    s_rresp;
    logic                          s_rvalid;
    logic                          s_rready;
    logic [ADDR_W-1:0]             s_awaddr;
    logic                          s_awvalid;
    logic                          s_awready;
    logic [DATA_W-1:0]             s_wdata;
    logic [DATA_W/8-1:0]           s_wstrb;
    logic                          s_wvalid;
    logic                          s_wready;
    logic [1:0]                    s_bresp;
    logic                          s_bvalid;
    logic                          s_bready;
`ifdef ARB_PERF_EN
    logic [NUM_MST*32-1:0]         perf_grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ysyx_23060240_axi_rr_arb #(
        .NUM_MST (NUM_MST),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready)
`ifdef ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every valid/ready output of the arbiter packed together.
    function automatic logic [19:0] hs_vec();
        return {m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input int m, input logic [31:0] addr);
        m_araddr[m*ADDR_W +: ADDR_W] = addr;
        m_arvalid[m] = 1'b1;
    endtask

    // Wait for the grant of a read to master m, then complete it.
    task automatic serve_read(input int m, input logic [31:0] addr,
                              input logic [31:0] data, input logic [1:0] resp);
        logic [2:0] oh;
        int  n;
        bit  seen;
        oh   = 3'(1 << m);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (s_arvalid) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            check_val("ar_timeout", 64'd0, 64'd1);
            tick();
        end else begin
            check_val("ar_grant", 64'(m_arready), 64'(oh));
            check_val("ar_addr", 64'(s_araddr), 64'(addr));
            check_val("ar_no_aw", 64'(s_awvalid), 64'd0);
            @(posedge clk);
            #1;
            m_arvalid[m] = 1'b0;
            s_rvalid = 1'b1;
            s_rdata  = data;
            s_rresp  = resp;
            @(negedge clk);
            check_val("r_valid", 64'(m_rvalid), 64'(oh));
            check_val("r_data", 64'(m_rdata), 64'(data));
            check_val("r_resp", 64'(m_rresp), 64'(resp));
            check_val("r_ready", 64'(s_rready), 64'd1);
            check_val("r_no_arready", 64'(m_arready), 64'd0);
            tick();
            s_rvalid = 1'b0;
        end
    endtask

    // Wait for the grant of a write (AW and W presented together) to m.
    task automatic serve_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] resp);
        logic [2:0] oh;
        int  n;
        bit  seen;
        oh   = 3'(1 << m);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (s_awvalid) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            check_val("aw_timeout", 64'd0, 64'd1);
            tick();
        end else begin
            check_val("aw_grant", 64'(m_awready), 64'(oh));
            check_val("aw_addr", 64'(s_awaddr), 64'(addr));
            check_val("w_valid", 64'(s_wvalid), 64'd1);
            check_val("w_data", 64'(s_wdata), 64'(data));
            check_val("w_strb", 64'(s_wstrb), 64'(strb));
            check_val("w_grant", 64'(m_wready), 64'(oh));
            @(posedge clk);
            #1;
            m_awvalid[m] = 1'b0;
            m_wvalid[m]  = 1'b0;
            s_bvalid = 1'b1;
            s_bresp  = resp;
            @(negedge clk);
            check_val("b_valid", 64'(m_bvalid), 64'(oh));
            check_val("b_resp", 64'(m_bresp), 64'(resp));
            check_val("b_ready", 64'(s_bready), 64'd1);
            tick();
            s_bvalid = 1'b0;
        end
    endtask

    task automatic set_wr(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
        m_awaddr[m*ADDR_W +: ADDR_W] = addr;
        m_wdata[m*DATA_W +: DATA_W]  = data;
        m_wstrb[m*4 +: 4]            = strb;
        m_awvalid[m] = 1'b1;
        m_wvalid[m]  = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        m_araddr  = '0;
        m_arvalid = '0;
        m_rready  = '1;
        m_awaddr  = '0;
        m_awvalid = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wvalid  = '0;
        m_bready  = '1;
        s_arready = 1'b1;
        s_rdata   = '0;
        s_rresp   = c_RESP_OKAY;
        s_rvalid  = 1'b0;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_bresp   = c_RESP_OKAY;
        s_bvalid  = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        check_val("reset_hs", 64'(hs_vec()), 64'd0);
        for (int i = 0; i < NUM_MST; i++) set_ar(i, 32'h100 * i);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_release_hs", 64'(hs_vec()), 64'd0);

        // ---------------- fairness: 0,1,2,0,1,2 ----------------
        for (int k = 0; k < 6; k++) begin
            serve_read(k % 3, 32'h100 * (k % 3), 32'hA5A5_0000 + 32'(k % 3), c_RESP_OKAY);
            if (k < 3) m_arvalid[k % 3] = 1'b1;
        end
        // rr_ptr now 0

        // ---------------- read preferred within master 0 ----------------
        set_ar(0, 32'h0000_0040);
        set_wr(0, 32'h0000_0080, 32'hDEAD_BEEF, 4'b1111);
        set_ar(2, 32'h0000_0240);
        serve_read(0, 32'h0000_0040, 32'h1111_0000, c_RESP_OKAY);
        serve_read(2, 32'h0000_0240, 32'h2222_0000, c_RESP_OKAY);
        serve_write(0, 32'h0000_0080, 32'hDEAD_BEEF, 4'b1111, c_RESP_OKAY);
        // rr_ptr now 1

        // ---------------- error codes pass through ----------------
        set_ar(1, 32'h0000_0140);
        serve_read(1, 32'h0000_0140, 32'h3333_0000, c_RESP_SLVERR);
        set_wr(1, 32'h0000_0180, 32'h4444_0000, 4'b1000);
        serve_write(1, 32'h0000_0180, 32'h4444_0000, 4'b1000, c_RESP_DECERR);
        // rr_ptr advanced to 2: master 2 beats master 1
        set_ar(1, 32'h0000_0144);
        set_ar(2, 32'h0000_0244);
        serve_read(2, 32'h0000_0244, 32'h5555_0000, c_RESP_OKAY);
        serve_read(1, 32'h0000_0144, 32'h6666_0000, c_RESP_OKAY);
        // rr_ptr now 2

        // ---------------- split write, master 1 ----------------
        m_awaddr[1*ADDR_W +: ADDR_W] = 32'h0000_2000;
        m_wdata[1*DATA_W +: DATA_W]  = 32'h1234_5678;
        m_wstrb[4 +: 4]              = 4'b0011;
        m_awvalid[1] = 1'b1;
        begin : split_wait
            int  n;
            bit  seen;
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 20) begin
                @(negedge clk);
                if (s_awvalid) seen = 1'b1;
                else n++;
            end
            if (!seen) check_val("split_aw_timeout", 64'd0, 64'd1);
        end
        check_val("split_aw_grant", 64'(m_awready), 64'b010);
        check_val("split_aw_addr", 64'(s_awaddr), 64'h2000);
        check_val("split_no_w", 64'(s_wvalid), 64'd0);
        check_val("split_no_bready0", 64'(s_bready), 64'd0);
        tick();
        // awvalid stays high: the done flag must keep it off the slave
        set_ar(0, 32'h0000_3000);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_val("split_aw_gated", 64'({s_awvalid, m_awready}), 64'd0);
            check_val("split_no_bready", 64'(s_bready), 64'd0);
            check_val("split_locked", 64'(s_arvalid), 64'd0);
            tick();
        end
        m_awvalid[1] = 1'b0;
        m_wvalid[1]  = 1'b1;
        @(negedge clk);
        check_val("split_w_valid", 64'(s_wvalid), 64'd1);
        check_val("split_w_data", 64'(s_wdata), 64'h1234_5678);
        check_val("split_w_strb", 64'(s_wstrb), 64'b0011);
        check_val("split_w_grant", 64'(m_wready), 64'b010);
        check_val("split_no_bready_w", 64'(s_bready), 64'd0);
        tick();
        m_wvalid[1] = 1'b0;
        s_bvalid    = 1'b1;
        s_bresp     = c_RESP_OKAY;
        m_bready[1] = 1'b0;
        @(negedge clk);
        check_val("split_bvalid_held", 64'(m_bvalid), 64'b010);
        check_val("split_bready_held", 64'(s_bready), 64'd0);
        check_val("split_locked_b", 64'(s_arvalid), 64'd0);
        tick();
        m_bready[1] = 1'b1;
        @(negedge clk);
        check_val("split_bvalid", 64'(m_bvalid), 64'b010);
        check_val("split_bready", 64'(s_bready), 64'd1);
        tick();
        s_bvalid = 1'b0;
        serve_read(0, 32'h0000_3000, 32'h7777_0000, c_RESP_OKAY);

        // ---------------- async reset mid-read ----------------
        set_ar(0, 32'h0000_0050);
        begin : rst_wait
            int  n;
            bit  seen;
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 20) begin
                @(negedge clk);
                if (s_arvalid) seen = 1'b1;
                else n++;
            end
            if (!seen) check_val("rst_ar_timeout", 64'd0, 64'd1);
        end
        tick();
        m_arvalid[0] = 1'b0;
        s_rvalid     = 1'b1;
        s_rdata      = 32'h8888_0000;
        @(negedge clk);
        check_val("rst_pre_rvalid", 64'(m_rvalid), 64'b001);
        #1;
        rst_n     = 1'b0;
        m_arvalid = '1;
        #1;
        check_val("rst_async_hs", 64'(hs_vec()), 64'd0);
        @(negedge clk);
        check_val("rst_held_hs", 64'(hs_vec()), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_release_hs", 64'(hs_vec()), 64'd0);
        #1;
        m_arvalid = '0;
        s_rvalid  = 1'b0;
        tick();

`ifdef ARB_PERF_EN
        // ---------------- grant counters ----------------
        check_val("perf_after_rst", 64'(perf_grant_cnt), 64'd0);
        for (int k = 0; k < 5; k++) begin
            set_ar(0, 32'h0000_0010);
            serve_read(0, 32'h0000_0010, 32'h0, c_RESP_OKAY);
        end
        for (int k = 0; k < 3; k++) begin
            set_ar(1, 32'h0000_0110);
            serve_read(1, 32'h0000_0110, 32'h0, c_RESP_OKAY);
        end
        check_val("perf_cnt", 64'(perf_grant_cnt[63:0]), {32'd3, 32'd5});
        check_val("perf_cnt2", 64'(perf_grant_cnt[95:64]), 64'd0);
        rst_n = 1'b0;
        #1;
        check_val("perf_cleared", 64'(perf_grant_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ysyx_23060240_axi_rr_arb
`default_nettype wire
